// File: rtl/blake2_core_arbiter_pkg.sv
// Shared types for the two-requester BLAKE2 core arbiter.
// FSM state encoding and requester count.
package blake2_core_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      BUSY        = 2'd1,
      WAIT_DIGEST = 2'd2,
      RELEASE     = 2'd3
   } state_t;

endpackage

// File: rtl/blake2_core_arbiter_rr_pick2.sv
// Two-way priority pick: the prio requester wins when it asks,
// otherwise the other one is chosen.
module rr_pick2
   import blake2_core_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               prio,
   output logic               idx,
   output logic               valid
);

   // Pick the prio holder if it requests, else fall back to the other.
   always_comb begin
      valid = |req;
      idx   = req[prio] ? prio : ~prio;
   end

endmodule

// File: rtl/blake2_core_arbiter.sv
// Session arbiter sharing one BLAKE2 core between two controllers.
// The owner keeps the core from grant until its digest is returned.
module blake2_core_arbiter
   import blake2_core_arbiter_pkg::*;
#(
   parameter int BLOCK_WIDTH  = 1024,
   parameter int LEN_WIDTH    = 64,
   parameter int DIGEST_WIDTH = 88
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                req,
   output logic [1:0]                gnt,
   input  logic [1:0]                init,
   input  logic [1:0]                next,
   input  logic [1:0]                final_block,
   input  logic [2*BLOCK_WIDTH-1:0]  block,
   input  logic [2*LEN_WIDTH-1:0]    data_length,
   output logic [1:0]                ready,
   output logic [1:0]                digest_valid,
   output logic [DIGEST_WIDTH-1:0]   digest,
   output logic                      core_init,
   output logic                      core_next,
   output logic                      core_final_block,
   output logic [BLOCK_WIDTH-1:0]    core_block,
   output logic [LEN_WIDTH-1:0]      core_data_length,
   input  logic                      core_ready,
   input  logic                      core_digest_valid,
   input  logic [DIGEST_WIDTH-1:0]   core_digest
);

   state_t state;
   logic   owner;
   logic   prio;
   logic   cmd_pend;
   logic   cmd_hold;
   logic   dv_prev;

   logic   pick_idx;
   logic   pick_valid;

   logic                   init_sel;
   logic                   next_sel;
   logic                   fin_sel;
   logic [BLOCK_WIDTH-1:0] blk_sel;
   logic [LEN_WIDTH-1:0]   len_sel;
   logic                   accept;
   logic                   dv_rise;

   rr_pick2 u_pick (
      .req   (req),
      .prio  (prio),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign ready = gnt &
      {2{core_ready & ~cmd_pend & (state == BUSY)}};

   // Route the owner's command inputs; the non-owner is never looked at.
   always_comb begin
      init_sel = owner ? init[1] : init[0];
      next_sel = owner ? next[1] : next[0];
      fin_sel  = owner ? final_block[1] : final_block[0];
      blk_sel  = owner ? block[2*BLOCK_WIDTH-1:BLOCK_WIDTH]
                       : block[BLOCK_WIDTH-1:0];
      len_sel  = owner ? data_length[2*LEN_WIDTH-1:LEN_WIDTH]
                       : data_length[LEN_WIDTH-1:0];
      accept   = (owner ? ready[1] : ready[0]) & (init_sel | next_sel);
      dv_rise  = core_digest_valid & ~dv_prev;
   end

   // Session FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= 1'b0;
         prio             <= 1'b0;
         cmd_pend         <= 1'b0;
         cmd_hold         <= 1'b0;
         dv_prev          <= 1'b0;
         gnt              <= 2'b00;
         digest_valid     <= 2'b00;
         digest           <= '0;
         core_init        <= 1'b0;
         core_next        <= 1'b0;
         core_final_block <= 1'b0;
         core_block       <= '0;
         core_data_length <= '0;
      end else begin
         core_init    <= 1'b0;
         core_next    <= 1'b0;
         digest_valid <= 2'b00;
         dv_prev      <= core_digest_valid;
         // cmd_pend stays up one extra cycle to cover core ready falling
         if (cmd_hold) cmd_hold <= 1'b0;
         else          cmd_pend <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_valid && core_ready) begin
                  owner <= pick_idx;
                  gnt   <= pick_idx ? 2'b10 : 2'b01;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (accept) begin
                  core_init        <= init_sel;
                  core_next        <= next_sel & ~init_sel;
                  core_final_block <= fin_sel;
                  core_block       <= blk_sel;
                  core_data_length <= len_sel;
                  cmd_pend         <= 1'b1;
                  cmd_hold         <= 1'b1;
                  if (next_sel && !init_sel && fin_sel)
                     state <= WAIT_DIGEST;
               end
            end
            WAIT_DIGEST: begin
               if (dv_rise) begin
                  digest       <= core_digest;
                  digest_valid <= owner ? 2'b10 : 2'b01;
                  state        <= RELEASE;
               end
            end
            RELEASE: begin
               gnt   <= 2'b00;
               prio  <= ~owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blake2_core_arbiter.sv
// Scoreboard bench for blake2_core_arbiter.
// Directed sessions; a negedge monitor checks core commands and digests.
module tb_blake2_core_arbiter;
   import blake2_core_arbiter_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    req = '0;
   logic [1:0]    gnt;
   logic [1:0]    init = '0;
   logic [1:0]    next = '0;
   logic [1:0]    final_block = '0;
   logic [2047:0] block = '0;
   logic [127:0]  data_length = '0;
   logic [1:0]    ready;
   logic [1:0]    digest_valid;
   logic [87:0]   digest;
   logic          core_init;
   logic          core_next;
   logic          core_final_block;
   logic [1023:0] core_block;
   logic [63:0]   core_data_length;
   logic          core_ready = 1'b1;
   logic          core_digest_valid = 1'b0;
   logic [87:0]   core_digest = '0;

   blake2_core_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .req               (req),
      .gnt               (gnt),
      .init              (init),
      .next              (next),
      .final_block       (final_block),
      .block             (block),
      .data_length       (data_length),
      .ready             (ready),
      .digest_valid      (digest_valid),
      .digest            (digest),
      .core_init         (core_init),
      .core_next         (core_next),
      .core_final_block  (core_final_block),
      .core_block        (core_block),
      .core_data_length  (core_data_length),
      .core_ready        (core_ready),
      .core_digest_valid (core_digest_valid),
      .core_digest       (core_digest)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ini;
      bit          nx;
      bit          fin;
      logic [15:0] tag;
   } cmd_t;

   typedef struct {
      logic [1:0]  who;
      logic [87:0] d;
   } dig_t;

   cmd_t cmd_q[$];
   dig_t dig_q[$];
   cmd_t mc;
   dig_t md;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit ini, input bit nx,
                        input bit fin, input logic [15:0] tag);
      init[i]                 = ini;
      next[i]                 = nx;
      final_block[i]          = fin;
      block[i*1024 +: 1024]   = {64{tag}};
      data_length[i*64 +: 64] = {4{tag}};
   endtask

   // Owner command that must be accepted; checks the ready mask window.
   task automatic cmd(input int i, input bit ini, input bit nx,
                      input bit fin, input logic [15:0] tag);
      cmd_t c;
      check("rdy_pre", ready[i], 1'b1);
      drive(i, ini, nx, fin, tag);
      c.ini = ini;
      c.nx  = nx & ~ini;
      c.fin = fin;
      c.tag = tag;
      cmd_q.push_back(c);
      tick();
      drive(i, 0, 0, 0, 16'h0);
      check("rdy_mask1", ready[i], 1'b0);
      tick();
      check("rdy_mask2", ready[i], 1'b0);
      tick();
      check("rdy_back", ready[i], (nx & fin & ~ini) ? 1'b0 : 1'b1);
   endtask

   task automatic digest_pulse(input logic [87:0] val,
                               input logic [1:0] who);
      dig_t d;
      d.who = who;
      d.d   = val;
      dig_q.push_back(d);
      core_digest       = val;
      core_digest_valid = 1'b1;
      tick();
      core_digest_valid = 1'b0;
      check("gnt_hold_dv", gnt, who);
      tick();
      check("gnt_release", gnt, 2'b00);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 2'b00;
      drive(0, 0, 0, 0, 16'h0);
      drive(1, 0, 0, 0, 16'h0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every core strobe and digest pulse must match the queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (core_init || core_next) begin
            if (cmd_q.size() == 0) begin
               check("core_cmd_unexpected", 1'b1, 1'b0);
            end else begin
               mc = cmd_q.pop_front();
               check("core_init", core_init, mc.ini);
               check("core_next", core_next, mc.nx);
               check("core_final", core_final_block, mc.fin);
               check("core_block_lo", core_block[127:0], {8{mc.tag}});
               check("core_block_hi", core_block[1023:896],
                     {8{mc.tag}});
               check("core_len", core_data_length, {4{mc.tag}});
            end
         end
         if (digest_valid != 2'b00) begin
            if (dig_q.size() == 0) begin
               check("digest_unexpected", digest_valid, 2'b00);
            end else begin
               md = dig_q.pop_front();
               check("digest_valid", digest_valid, md.who);
               check("digest", digest, md.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check("rst_gnt", gnt, 2'b00);
      check("rst_ready", ready, 2'b00);
      check("rst_dv", digest_valid, 2'b00);
      check("rst_strobes",
            {core_init, core_next, core_final_block}, 3'b000);
      check("rst_digest", digest, 88'h0);
      check("rst_block", core_block[127:0], 128'h0);
      check("rst_len", core_data_length, 64'h0);
      check("rst_state", dut.state, IDLE);

      // Single session by requester 0
      req = 2'b01;
      tick();
      check("t1_gnt", gnt, 2'b01);
      check("t1_ready", ready, 2'b01);
      cmd(0, 1, 0, 0, 16'h1001);
      cmd(0, 0, 1, 0, 16'h1002);
      cmd(0, 0, 1, 0, 16'h1003);
      cmd(0, 0, 1, 0, 16'h1004);
      cmd(0, 0, 1, 1, 16'h1005);
      req = 2'b00;
      tick();
      digest_pulse({11{8'hA5}}, 2'b01);
      tick();
      check("t1_no_regrant", gnt, 2'b00);
      check("t1_digest_held", digest, {11{8'hA5}});

      // Contention from reset, with non-owner noise and ready masking
      do_reset();
      req = 2'b11;
      tick();
      check("t2_gnt0", gnt, 2'b01);
      check("t2_rdy1_off", ready[1], 1'b0);
      drive(1, 1, 0, 0, 16'hBAD0);
      tick();
      check("t2_nonown_rdy", ready[1], 1'b0);
      drive(1, 0, 1, 1, 16'hBAD1);
      tick();
      check("t2_nonown_rdy2", ready[1], 1'b0);
      cmd(0, 1, 1, 0, 16'h2001);
      drive(1, 0, 0, 0, 16'h0);
      check("t2_rdy_pre_dbl", ready[0], 1'b1);
      drive(0, 0, 1, 0, 16'h2002);
      mc.ini = 0; mc.nx = 1; mc.fin = 0; mc.tag = 16'h2002;
      cmd_q.push_back(mc);
      tick();
      drive(0, 0, 1, 0, 16'h2BAD);
      check("t2_dbl_mask1", ready[0], 1'b0);
      tick();
      drive(0, 0, 0, 0, 16'h0);
      check("t2_dbl_mask2", ready[0], 1'b0);
      tick();
      check("t2_dbl_back", ready[0], 1'b1);
      cmd(0, 0, 1, 1, 16'h2003);
      digest_pulse({11{8'h3C}}, 2'b01);
      tick();
      check("t2_gnt1", gnt, 2'b10);
      cmd(1, 1, 0, 0, 16'h2101);
      cmd(1, 0, 1, 1, 16'h2102);
      digest_pulse({11{8'h5A}}, 2'b10);
      tick();
      check("t2_gnt0_again", gnt, 2'b01);

      // Owner drops req after init; session runs to the digest
      cmd(0, 1, 0, 0, 16'h3001);
      req = 2'b00;
      tick();
      tick();
      check("t3_gnt_held", gnt, 2'b01);
      cmd(0, 0, 1, 1, 16'h3002);
      digest_pulse({11{8'hC3}}, 2'b01);

      // Reset while waiting for the digest
      req = 2'b01;
      tick();
      check("t4_gnt", gnt, 2'b01);
      cmd(0, 1, 0, 0, 16'h4001);
      cmd(0, 0, 1, 1, 16'h4002);
      req   = 2'b00;
      reset = 1'b1;
      tick();
      check("t4_rst_gnt", gnt, 2'b00);
      check("t4_rst_state", dut.state, IDLE);
      reset             = 1'b0;
      core_digest       = {11{8'h77}};
      core_digest_valid = 1'b1;
      tick();
      check("t4_no_dv1", digest_valid, 2'b00);
      tick();
      check("t4_no_dv2", digest_valid, 2'b00);
      core_digest_valid = 1'b0;
      tick();
      check("t4_no_dv3", digest_valid, 2'b00);
      check("t4_digest_clr", digest, 88'h0);

      tick();
      check("cmd_q_empty", cmd_q.size(), 0);
      check("dig_q_empty", dig_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/blake2_core_arbiter.md
# blake2_core_arbiter

Two-requester round-robin arbiter sharing one BLAKE2 core between two block controllers. Grants the core for a whole hash session (init through final digest), registers and forwards the owner's command strobes, masks ready from the non-owner, captures the digest and returns it to the owner only. Sits between the controller instances and a single blake2_core.

## Interface
- BLOCK_WIDTH, 1024, message block width
- LEN_WIDTH, 64, data_length width
- DIGEST_WIDTH, 88, core digest width
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- req  in  2  per-requester session request, level
- gnt  out  2  one-hot session grant, registered
- init, next, final_block  in  2 each  per-requester command strobes, one-cycle pulses
- block  in  2*BLOCK_WIDTH  per-requester block; requester i in slice i
- data_length  in  2*LEN_WIDTH  per-requester length
- ready  out  2  per-requester ready
- digest_valid  out  2  per-requester one-cycle digest pulse
- digest  out  DIGEST_WIDTH  captured digest, held until next capture
- core_init, core_next, core_final_block  out  1 each  registered strobes to core
- core_block  out  BLOCK_WIDTH; core_data_length  out  LEN_WIDTH  registered
- core_ready  in  1; core_digest_valid  in  1 (level); core_digest  in  DIGEST_WIDTH

## Operation
- States: IDLE, BUSY, WAIT_DIGEST, RELEASE. owner (1 bit), prio (1 bit), cmd_pend (1 bit).
- IDLE: if any req and core_ready: grant req[prio] if set, else the other; load owner, gnt set next cycle, go BUSY.
- BUSY: owner's init/next accepted when ready[owner]=1; on accept, strobe and block/data_length/final_block registered onto core_* next cycle (one-cycle pulse); cmd_pend set for 2 cycles to cover core ready fall.
- Accepted next with final_block=1: go WAIT_DIGEST.
- WAIT_DIGEST: on rising edge of core_digest_valid (sampled 0 then 1), capture core_digest into digest, pulse digest_valid[owner], go RELEASE.
- RELEASE: gnt cleared, prio set to ~owner; IDLE next cycle.
- ready[i] = core_ready & gnt[i] & ~cmd_pend & (state==BUSY).
- Non-owner strobes ignored, never reach the core. Owner strobes while ready=0 are dropped (protocol violation; not queued).
- init and next in same cycle: init wins, next dropped.
- req dropped by owner mid-session: ignored; session ends only at digest (core has no abort).
- digest_valid edge outside WAIT_DIGEST ignored.

## Timing
- Reset: state IDLE, owner 0, prio 0, cmd_pend 0; gnt, ready, digest_valid, core_init/next/final_block all 0; digest, core_block, core_data_length 0.
- Request to grant: req sampled in cycle N, gnt high from N+1, ready may assert N+1.
- Command latency: owner strobe in cycle N -> core strobe in N+1; ready[owner] low N+1..N+2, then follows core_ready.
- Digest: core_digest_valid rises in cycle N -> digest and digest_valid[owner] at N+1; gnt low at N+2; next grant earliest N+3.
- Both req asserted in IDLE: prio holder wins; alternation guaranteed after every completed session.
- reset mid-session: arbiter returns to IDLE next edge; core must share same reset.

## Structure
- Shared package: state encoding (IDLE=0, BUSY=1, WAIT_DIGEST=2, RELEASE=3), requester count constant 2.
- One natural sub-module: rr_pick2 (combinational prio-based pick, returns winner index and valid); rest is one FSM module.

## Test plan
- Single session: req=01, init, 4 next, last with final_block=1, core digest 88'hA5... -> gnt=01 one cycle after req, 5 core strobes each delayed 1 cycle, digest_valid=01 with digest=88'hA5..., gnt=00 two cycles later.
- Contention: req=11 from reset -> requester 0 served first, requester 1 granted 3 cycles after digest rise; second simultaneous request after both -> requester 0 again (prio alternates).
- Non-owner stimulus: requester 1 pulses init/next during requester 0 session -> core_* show only requester 0 commands, ready[1]=0 throughout.
- Ready masking: owner pulses next on two consecutive cycles -> only first reaches core; ready[owner]=0 for two cycles after accept.
- Owner drops req after init -> session continues; gnt held until digest_valid pulse.
- Reset asserted in WAIT_DIGEST -> next cycle gnt=00, state IDLE, no digest_valid pulse even if core_digest_valid rises.
